sram_arbiter: RTL

//  Shares the single 16-bit asynchronous board SRAM between three requesters:
//  - the SD boot loader (boot port);
//  - the CPU data port (dmem);
//  - the CPU instruction port (imem).

---
 rtl/sram_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Three-port arbiter for the board's 16-bit asynchronous SRAM (boot > dmem > imem).
// Define ARB_RR_EN to alternate dmem/imem grants through a round-robin pointer.
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_done,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [15:0]       boot_wdata,
  output logic              boot_ack,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [1:0]        dmem_be,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [15:0]       dmem_wdata,
  output logic [15:0]       dmem_rdata,
  output logic              dmem_ack,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_rdata,
  output logic              imem_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_e;
  typedef enum logic [1:0] {OWN_BOOT, OWN_DMEM, OWN_IMEM} owner_e;

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       dmem_rdata_q, dmem_rdata_d;
  logic [15:0]       imem_rdata_q, imem_rdata_d;

  logic dmem_elig, imem_elig, pick_imem;
  logic in_access, in_recover;

`ifdef ARB_RR_EN
  logic rr_q, rr_d;

  // rr_q=1 means imem wins the next dmem/imem tie.
  always_comb begin
    dmem_elig = boot_done & dmem_req;
    imem_elig = boot_done & imem_req;
    pick_imem = imem_elig & (~dmem_elig | rr_q);
  end
`else
  always_comb begin
    dmem_elig = boot_done & dmem_req;
    imem_elig = boot_done & imem_req;
    pick_imem = imem_elig & ~dmem_elig;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_BOOT;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      dmem_rdata_q <= '0;
      imem_rdata_q <= '0;
`ifdef ARB_RR_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_rdata_q <= imem_rdata_d;
`ifdef ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_rdata_d = imem_rdata_q;
`ifdef ARB_RR_EN
    rr_d         = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (boot_req) begin
          state_d = ACCESS;
          owner_d = OWN_BOOT;
          we_d    = 1'b1;
          be_d    = 2'b11;
          addr_d  = boot_addr;
          wdata_d = boot_wdata;
        end else if (pick_imem) begin
          state_d = ACCESS;
          owner_d = OWN_IMEM;
          we_d    = 1'b0;
          be_d    = 2'b11;
          addr_d  = imem_addr;
`ifdef ARB_RR_EN
          rr_d    = 1'b0;
`endif
        end else if (dmem_elig) begin
          state_d = ACCESS;
          owner_d = OWN_DMEM;
          we_d    = dmem_we;
          be_d    = dmem_be;
          addr_d  = dmem_addr;
          wdata_d = dmem_wdata;
`ifdef ARB_RR_EN
          rr_d    = 1'b1;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == WaitLast) begin
          state_d = RECOVER;
          // Sample DQ while oe_n is still low so the data is stable for the ack cycle.
          if (!we_q && owner_q == OWN_DMEM) dmem_rdata_d = sram_dq_in;
          if (!we_q && owner_q == OWN_IMEM) imem_rdata_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write data stay on the pins through RECOVER to meet SRAM hold time.
  always_comb begin
    in_access   = (state_q == ACCESS);
    in_recover  = (state_q == RECOVER);
    sram_addr   = addr_q;
    sram_dq_out = wdata_q;
    sram_dq_oe  = we_q & (in_access | in_recover);
    sram_we_n   = ~(in_access & we_q);
    sram_oe_n   = ~(in_access & ~we_q);
    sram_ub_n   = ~(in_access & be_q[1]);
    sram_lb_n   = ~(in_access & be_q[0]);
    boot_ack    = in_recover & (owner_q == OWN_BOOT);
    dmem_ack    = in_recover & (owner_q == OWN_DMEM);
    imem_ack    = in_recover & (owner_q == OWN_IMEM);
    dmem_rdata  = dmem_rdata_q;
    imem_rdata  = imem_rdata_q;
  end

endmodule
